hr_bridge: RTL and testbench
============================

# hr_bridge

Bufferless bridge router joining one local ring (two lanes, l0/l1) to the global ring (four lanes, g0..g3) in the hierarchical-ring NoC. Every lane passes through a one-flit pipeline register. Flits that must change ring are ejected into the opposite ring's transfer FIFO; heads of the transfer FIFOs are injected into free lane slots. Flits that cannot be ejected are deflected, i.e. they stay on their ring.

## Interface
- ADDR, 4'b0000: bridge address; ADDR[3:2] identifies the attached local ring.
- Flit format (`control_w`, 144 bits):
  - [12] valid
  - [3:0] dst: dst[3:2] is the ring id, dst[3] is the global lane-pair select
  - all other bits are payload, carried unchanged
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- For each X in {l0, l1, g0, g1, g2, g3}:
  - port_X_i  in  144  flit arriving on lane X.
  - port_X_o  out  144  registered flit leaving on lane X.
  - FIFO_X_i  in  144  head of the transfer FIFO that injects onto lane X.
  - FIFO_X_o  out  144  flit to enqueue into FIFO X; zero when enQ_X_o=0.
  - bfull_X_i  in  1  FIFO X is full; enqueue into FIFO X is forbidden.
  - deQ_X_o  out  1  pop the head of FIFO X this cycle.
  - enQ_X_o  out  1  push FIFO_X_o into FIFO X this cycle.

## Operation
- **Crossing test:**
  - A valid flit on l0/l1 crosses when dst[3:2] != ADDR[3:2].
  - A valid flit on g0..g3 crosses when dst[3:2] == ADDR[3:2].
- **Eject targets:**
  - l0 goes to g0 when dst[3]=0, else to g2.
  - l1 goes to g1 when dst[3]=0, else to g3.
  - g0 and g2 go to l0; g1 and g3 go to l1.
- **Eject condition:** the flit crosses, bfull of the target FIFO is 0, and the flit wins arbitration.
  - Local→global targets are unique, so no arbitration is needed.
  - g0 vs g2 (for FIFO l0) and g1 vs g3 (for FIFO l1) use fixed priority: the lower index wins.
  - A flit that does not eject is deflected: it is passed to port_X_o of its own lane unchanged.
- **Slot free:** lane X's slot is free when port_X_i is invalid or was ejected this cycle.
- **Injection:**
  - When the slot is free and FIFO_X_i[12]=1: port_X_o <= FIFO_X_i and deQ_X_o=1.
  - Injection ignores bfull_X_i.
- **Empty slot:** when the slot is free and nothing is injected, port_X_o <= 0.
- **Enqueue outputs:**
  - enQ_Y_o=1 and FIFO_Y_o = the ejected flit for each FIFO Y receiving an ejection.
  - All other enQ_Y_o=0 and FIFO_Y_o=0.
- No flit is ever dropped or duplicated. Payload bits pass through unchanged.

## Timing
- port_X_o registers update on posedge clk; lane latency is exactly 1 cycle.
- deQ_X_o, enQ_X_o and FIFO_X_o are combinational from the current inputs. The FIFO acts on them at the same posedge.
- Reset:
  - rst=1 clears all port_X_o to 0 asynchronously.
  - While rst=1, all deQ/enQ/FIFO_o are forced to 0.
  - When rst falls mid-stream, operation resumes on the next edge with empty lanes.
- **Simultaneous events:**
  - Ejection and injection on the same lane in the same cycle are both legal: the ejected flit goes to the FIFO and the injected flit takes the slot.
  - When bfull is 1 on an eject target, the crossing flit is deflected, so that lane's slot is occupied and no injection occurs.

## Configuration
- HR_EJECT_RR_EN:
  - Defined: each local FIFO has a 1-bit round-robin pointer (reset 0 = lower index wins). On every cycle where both contenders are crossing and eligible, the winner is taken from the pointer and the pointer then toggles.
  - Undefined: fixed lower-index priority and no pointer state.

## Test plan
- **Injection into empty ring:**
  - Stimulus: all port_X_i=0, all bfull=1, FIFO heads valid (FIFO_l0_i=...1854, FIFO_l1_i=...185f, FIFO_g0_i..FIFO_g3_i=...1850..1853), one clock.
  - Response: every port_X_o equals its FIFO_X_i, all deQ=1, all enQ=0, all FIFO_o=0.
- **Drain:**
  - Stimulus: then drive all inputs and bfull to 0, one clock.
  - Response: all port_X_o=0, all deQ=0, all enQ=0.
- **Local→global crossing:**
  - Stimulus: ADDR=0, port_l0_i valid with dst=4'h4, bfull_g0=0.
  - Response: same cycle enQ_g0_o=1 and FIFO_g0_o = the flit; FIFO_l0 head is injected onto port_l0_o.
- **Global→local contention:**
  - Stimulus: g0 and g2 both carry valid dst=4'h1, bfull_l0=0.
  - Response (fixed priority): g0 ejects to l0; the g2 flit appears on port_g2_o next cycle.
  - Response (with HR_EJECT_RR_EN): the winner alternates on repeated conflicts.
- **Deflection on full:**
  - Stimulus: crossing flit on l1 with bfull_g1=1, FIFO_l1 head valid.
  - Response: the flit appears on port_l1_o next cycle; enQ_g1=0; deQ_l1=0.
- **Asynchronous reset:**
  - Stimulus: assert rst mid-cycle with lanes full.
  - Response: all port_X_o go to 0 immediately; deQ/enQ are held 0 while rst=1.

Source files
------------

// File: rtl/hr_bridge.sv
// Bridge router between one local ring (l0/l1) and the global ring (g0..g3).
// Optional feature macro HR_EJECT_RR_EN: round-robin arbitration on the local transfer FIFOs.
module hr_bridge #(
    parameter logic [3:0] ADDR = 4'b0000
) (
    input  logic         clk,
    input  logic         rst,

    input  logic [143:0] port_l0_i,
    input  logic [143:0] port_l1_i,
    input  logic [143:0] port_g0_i,
    input  logic [143:0] port_g1_i,
    input  logic [143:0] port_g2_i,
    input  logic [143:0] port_g3_i,

    output logic [143:0] port_l0_o,
    output logic [143:0] port_l1_o,
    output logic [143:0] port_g0_o,
    output logic [143:0] port_g1_o,
    output logic [143:0] port_g2_o,
    output logic [143:0] port_g3_o,

    input  logic [143:0] FIFO_l0_i,
    input  logic [143:0] FIFO_l1_i,
    input  logic [143:0] FIFO_g0_i,
    input  logic [143:0] FIFO_g1_i,
    input  logic [143:0] FIFO_g2_i,
    input  logic [143:0] FIFO_g3_i,

    output logic [143:0] FIFO_l0_o,
    output logic [143:0] FIFO_l1_o,
    output logic [143:0] FIFO_g0_o,
    output logic [143:0] FIFO_g1_o,
    output logic [143:0] FIFO_g2_o,
    output logic [143:0] FIFO_g3_o,

    input  logic         bfull_l0_i,
    input  logic         bfull_l1_i,
    input  logic         bfull_g0_i,
    input  logic         bfull_g1_i,
    input  logic         bfull_g2_i,
    input  logic         bfull_g3_i,

    output logic         deQ_l0_o,
    output logic         deQ_l1_o,
    output logic         deQ_g0_o,
    output logic         deQ_g1_o,
    output logic         deQ_g2_o,
    output logic         deQ_g3_o,

    output logic         enQ_l0_o,
    output logic         enQ_l1_o,
    output logic         enQ_g0_o,
    output logic         enQ_g1_o,
    output logic         enQ_g2_o,
    output logic         enQ_g3_o
);

    localparam int VALID_BIT = 12;
    localparam int L0 = 0;
    localparam int L1 = 1;
    localparam int G0 = 2;
    localparam int G1 = 3;
    localparam int G2 = 4;
    localparam int G3 = 5;

    logic [5:0][143:0] lane_in;
    logic [5:0][143:0] fifo_head;
    logic [5:0][143:0] lane_q;
    logic [5:0][143:0] lane_next;
    logic [5:0][143:0] enq_flit;
    logic [5:0]        bfull;
    logic [5:0]        crosses;
    logic [5:0]        eject;
    logic [5:0]        enq;
    logic [5:0]        deq;
    logic [5:0]        slot_free;
    logic              g0_ok, g1_ok, g2_ok, g3_ok;
    logic [1:0]        take_hi;

    assign lane_in   = {port_g3_i, port_g2_i, port_g1_i, port_g0_i, port_l1_i, port_l0_i};
    assign fifo_head = {FIFO_g3_i, FIFO_g2_i, FIFO_g1_i, FIFO_g0_i, FIFO_l1_i, FIFO_l0_i};
    assign bfull     = {bfull_g3_i, bfull_g2_i, bfull_g1_i, bfull_g0_i, bfull_l1_i, bfull_l0_i};

    // Local flits leave when addressed to another ring; global flits leave when addressed here.
    for (genvar i = 0; i < 6; i++) begin : g_lane
        if (i < 2) begin : g_local
            assign crosses[i] = lane_in[i][VALID_BIT] && (lane_in[i][3:2] != ADDR[3:2]);
        end else begin : g_global
            assign crosses[i] = lane_in[i][VALID_BIT] && (lane_in[i][3:2] == ADDR[3:2]);
        end
        assign slot_free[i] = !lane_in[i][VALID_BIT] || eject[i];
        assign deq[i]       = !rst && slot_free[i] && fifo_head[i][VALID_BIT];
        assign lane_next[i] = !slot_free[i]                ? lane_in[i]   :
                              fifo_head[i][VALID_BIT]      ? fifo_head[i] : '0;
    end

    assign g0_ok = crosses[G0] && !bfull[L0];
    assign g2_ok = crosses[G2] && !bfull[L0];
    assign g1_ok = crosses[G1] && !bfull[L1];
    assign g3_ok = crosses[G3] && !bfull[L1];

`ifdef HR_EJECT_RR_EN
    logic [1:0] rr_ptr;

    // Pointer only advances on an actual conflict, so an uncontested flit never steals a turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            if (g0_ok && g2_ok) rr_ptr[0] <= ~rr_ptr[0];
            if (g1_ok && g3_ok) rr_ptr[1] <= ~rr_ptr[1];
        end
    end

    assign take_hi = rr_ptr;
`else
    assign take_hi = 2'b00;
`endif

    always_comb begin
        eject    = '0;
        enq      = '0;
        enq_flit = '0;

        if (crosses[L0]) begin
            if (!lane_in[L0][3] && !bfull[G0]) begin
                eject[L0] = 1'b1; enq[G0] = 1'b1; enq_flit[G0] = lane_in[L0];
            end else if (lane_in[L0][3] && !bfull[G2]) begin
                eject[L0] = 1'b1; enq[G2] = 1'b1; enq_flit[G2] = lane_in[L0];
            end
        end
        if (crosses[L1]) begin
            if (!lane_in[L1][3] && !bfull[G1]) begin
                eject[L1] = 1'b1; enq[G1] = 1'b1; enq_flit[G1] = lane_in[L1];
            end else if (lane_in[L1][3] && !bfull[G3]) begin
                eject[L1] = 1'b1; enq[G3] = 1'b1; enq_flit[G3] = lane_in[L1];
            end
        end

        // The higher-index contender wins only if the lower one is absent or it is its turn.
        if (g0_ok && !(g2_ok && take_hi[0])) begin
            eject[G0] = 1'b1; enq[L0] = 1'b1; enq_flit[L0] = lane_in[G0];
        end else if (g2_ok) begin
            eject[G2] = 1'b1; enq[L0] = 1'b1; enq_flit[L0] = lane_in[G2];
        end
        if (g1_ok && !(g3_ok && take_hi[1])) begin
            eject[G1] = 1'b1; enq[L1] = 1'b1; enq_flit[L1] = lane_in[G1];
        end else if (g3_ok) begin
            eject[G3] = 1'b1; enq[L1] = 1'b1; enq_flit[L1] = lane_in[G3];
        end

        if (rst) begin
            enq      = '0;
            enq_flit = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lane_q <= '0;
        else     lane_q <= lane_next;
    end

    assign port_l0_o = lane_q[L0];
    assign port_l1_o = lane_q[L1];
    assign port_g0_o = lane_q[G0];
    assign port_g1_o = lane_q[G1];
    assign port_g2_o = lane_q[G2];
    assign port_g3_o = lane_q[G3];

    assign FIFO_l0_o = enq_flit[L0];
    assign FIFO_l1_o = enq_flit[L1];
    assign FIFO_g0_o = enq_flit[G0];
    assign FIFO_g1_o = enq_flit[G1];
    assign FIFO_g2_o = enq_flit[G2];
    assign FIFO_g3_o = enq_flit[G3];

    assign deQ_l0_o = deq[L0];
    assign deQ_l1_o = deq[L1];
    assign deQ_g0_o = deq[G0];
    assign deQ_g1_o = deq[G1];
    assign deQ_g2_o = deq[G2];
    assign deQ_g3_o = deq[G3];

    assign enQ_l0_o = enq[L0];
    assign enQ_l1_o = enq[L1];
    assign enQ_g0_o = enq[G0];
    assign enQ_g1_o = enq[G1];
    assign enQ_g2_o = enq[G2];
    assign enQ_g3_o = enq[G3];

endmodule

// File: tb/tb_hr_bridge.sv
// Directed self-checking bench for hr_bridge (ADDR = 0).
// Vector order for deq/enq bundles is {l0, l1, g0, g1, g2, g3}.
module tb_hr_bridge;

    logic         clk;
    logic         rst;
    logic [143:0] port_l0_i, port_l1_i, port_g0_i, port_g1_i, port_g2_i, port_g3_i;
    logic [143:0] port_l0_o, port_l1_o, port_g0_o, port_g1_o, port_g2_o, port_g3_o;
    logic [143:0] FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i, FIFO_g2_i, FIFO_g3_i;
    logic [143:0] FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o, FIFO_g2_o, FIFO_g3_o;
    logic         bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i, bfull_g2_i, bfull_g3_i;
    logic         deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o, deQ_g2_o, deQ_g3_o;
    logic         enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o, enQ_g2_o, enQ_g3_o;

    logic [5:0]   deq_vec;
    logic [5:0]   enq_vec;
    logic [143:0] fifo_or;
    logic [143:0] out_or;

    int tests_run;
    int tests_failed;

    localparam logic [127:0] PH = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    hr_bridge #(.ADDR(4'b0000)) dut (
        .clk(clk), .rst(rst),
        .port_l0_i(port_l0_i), .port_l1_i(port_l1_i), .port_g0_i(port_g0_i),
        .port_g1_i(port_g1_i), .port_g2_i(port_g2_i), .port_g3_i(port_g3_i),
        .port_l0_o(port_l0_o), .port_l1_o(port_l1_o), .port_g0_o(port_g0_o),
        .port_g1_o(port_g1_o), .port_g2_o(port_g2_o), .port_g3_o(port_g3_o),
        .FIFO_l0_i(FIFO_l0_i), .FIFO_l1_i(FIFO_l1_i), .FIFO_g0_i(FIFO_g0_i),
        .FIFO_g1_i(FIFO_g1_i), .FIFO_g2_i(FIFO_g2_i), .FIFO_g3_i(FIFO_g3_i),
        .FIFO_l0_o(FIFO_l0_o), .FIFO_l1_o(FIFO_l1_o), .FIFO_g0_o(FIFO_g0_o),
        .FIFO_g1_o(FIFO_g1_o), .FIFO_g2_o(FIFO_g2_o), .FIFO_g3_o(FIFO_g3_o),
        .bfull_l0_i(bfull_l0_i), .bfull_l1_i(bfull_l1_i), .bfull_g0_i(bfull_g0_i),
        .bfull_g1_i(bfull_g1_i), .bfull_g2_i(bfull_g2_i), .bfull_g3_i(bfull_g3_i),
        .deQ_l0_o(deQ_l0_o), .deQ_l1_o(deQ_l1_o), .deQ_g0_o(deQ_g0_o),
        .deQ_g1_o(deQ_g1_o), .deQ_g2_o(deQ_g2_o), .deQ_g3_o(deQ_g3_o),
        .enQ_l0_o(enQ_l0_o), .enQ_l1_o(enQ_l1_o), .enQ_g0_o(enQ_g0_o),
        .enQ_g1_o(enQ_g1_o), .enQ_g2_o(enQ_g2_o), .enQ_g3_o(enQ_g3_o)
    );

    assign deq_vec = {deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o, deQ_g2_o, deQ_g3_o};
    assign enq_vec = {enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o, enQ_g2_o, enQ_g3_o};
    assign fifo_or = FIFO_l0_o | FIFO_l1_o | FIFO_g0_o | FIFO_g1_o | FIFO_g2_o | FIFO_g3_o;
    assign out_or  = port_l0_o | port_l1_o | port_g0_o | port_g1_o | port_g2_o | port_g3_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [143:0] flit(input logic [15:0] lo);
        return {PH, lo};
    endfunction

    task automatic check_output(input string tag, input logic [143:0] observed,
                                input logic [143:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus_idle();
        port_l0_i = '0; port_l1_i = '0; port_g0_i = '0;
        port_g1_i = '0; port_g2_i = '0; port_g3_i = '0;
        FIFO_l0_i = '0; FIFO_l1_i = '0; FIFO_g0_i = '0;
        FIFO_g1_i = '0; FIFO_g2_i = '0; FIFO_g3_i = '0;
        bfull_l0_i = 1'b0; bfull_l1_i = 1'b0; bfull_g0_i = 1'b0;
        bfull_g1_i = 1'b0; bfull_g2_i = 1'b0; bfull_g3_i = 1'b0;
    endtask

    task automatic apply_stimulus_heads();
        FIFO_l0_i = flit(16'h1854); FIFO_l1_i = flit(16'h185f);
        FIFO_g0_i = flit(16'h1850); FIFO_g1_i = flit(16'h1851);
        FIFO_g2_i = flit(16'h1852); FIFO_g3_i = flit(16'h1853);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with valid heads and crossing flits present: outputs must stay quiet.
        rst = 1'b1;
        apply_stimulus_idle();
        apply_stimulus_heads();
        port_l0_i = flit(16'h1004);
        port_g0_i = flit(16'h1001);
        @(posedge clk); #1;
        check_output("reset_out", out_or, '0);
        check_output("reset_deq", {138'd0, deq_vec}, '0);
        check_output("reset_enq", {138'd0, enq_vec}, '0);
        check_output("reset_fifo_o", fifo_or, '0);

        // Injection into an empty ring with every FIFO full.
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus_idle();
        apply_stimulus_heads();
        bfull_l0_i = 1'b1; bfull_l1_i = 1'b1; bfull_g0_i = 1'b1;
        bfull_g1_i = 1'b1; bfull_g2_i = 1'b1; bfull_g3_i = 1'b1;
        #1;
        check_output("inj_deq", {138'd0, deq_vec}, {138'd0, 6'b111111});
        check_output("inj_enq", {138'd0, enq_vec}, '0);
        check_output("inj_fifo_o", fifo_or, '0);
        @(posedge clk); #1;
        check_output("inj_l0", port_l0_o, flit(16'h1854));
        check_output("inj_l1", port_l1_o, flit(16'h185f));
        check_output("inj_g0", port_g0_o, flit(16'h1850));
        check_output("inj_g1", port_g1_o, flit(16'h1851));
        check_output("inj_g2", port_g2_o, flit(16'h1852));
        check_output("inj_g3", port_g3_o, flit(16'h1853));

        // Drain.
        @(negedge clk);
        apply_stimulus_idle();
        #1;
        check_output("drain_deq", {138'd0, deq_vec}, '0);
        check_output("drain_enq", {138'd0, enq_vec}, '0);
        @(posedge clk); #1;
        check_output("drain_out", out_or, '0);

        // Local to global: l0 dst 4 -> g0, l1 dst C -> g3; l0 slot refilled from its FIFO.
        @(negedge clk);
        apply_stimulus_idle();
        port_l0_i = flit(16'h1004);
        port_l1_i = flit(16'h100c);
        FIFO_l0_i = flit(16'h1aa0);
        #1;
        check_output("l2g_enq", {138'd0, enq_vec}, {138'd0, 6'b001001});
        check_output("l2g_fifo_g0", FIFO_g0_o, flit(16'h1004));
        check_output("l2g_fifo_g3", FIFO_g3_o, flit(16'h100c));
        check_output("l2g_deq", {138'd0, deq_vec}, {138'd0, 6'b100000});
        @(posedge clk); #1;
        check_output("l2g_out_l0", port_l0_o, flit(16'h1aa0));
        check_output("l2g_out_l1", port_l1_o, '0);

        // Global to local contention on FIFO l0; g1 ejects to l1 and its slot is refilled.
        @(negedge clk);
        apply_stimulus_idle();
        port_g0_i = flit(16'h1a01);
        port_g2_i = flit(16'h1b01);
        port_g1_i = flit(16'h1002);
        port_g3_i = flit(16'h1004);
        FIFO_g1_i = flit(16'h1cc5);
        #1;
        check_output("g2l_enq", {138'd0, enq_vec}, {138'd0, 6'b110000});
        check_output("g2l_fifo_l0", FIFO_l0_o, flit(16'h1a01));
        check_output("g2l_fifo_l1", FIFO_l1_o, flit(16'h1002));
        check_output("g2l_deq", {138'd0, deq_vec}, {138'd0, 6'b000100});
        @(posedge clk); #1;
        check_output("g2l_out_g0", port_g0_o, '0);
        check_output("g2l_out_g2", port_g2_o, flit(16'h1b01));
        check_output("g2l_out_g1", port_g1_o, flit(16'h1cc5));
        check_output("g2l_out_g3", port_g3_o, flit(16'h1004));

        // Same conflict again: round-robin hands the second one to g2.
        @(negedge clk);
        #1;
`ifdef HR_EJECT_RR_EN
        check_output("g2l2_fifo_l0", FIFO_l0_o, flit(16'h1b01));
`else
        check_output("g2l2_fifo_l0", FIFO_l0_o, flit(16'h1a01));
`endif
        @(posedge clk); #1;
`ifdef HR_EJECT_RR_EN
        check_output("g2l2_out_g0", port_g0_o, flit(16'h1a01));
        check_output("g2l2_out_g2", port_g2_o, '0);
`else
        check_output("g2l2_out_g0", port_g0_o, '0);
        check_output("g2l2_out_g2", port_g2_o, flit(16'h1b01));
`endif

        // Deflection on full target: slot stays occupied, no injection.
        @(negedge clk);
        apply_stimulus_idle();
        port_l1_i  = flit(16'h1004);
        bfull_g1_i = 1'b1;
        FIFO_l1_i  = flit(16'h1dd7);
        #1;
        check_output("defl_enq", {138'd0, enq_vec}, '0);
        check_output("defl_deq", {138'd0, deq_vec}, '0);
        @(posedge clk); #1;
        check_output("defl_out_l1", port_l1_o, flit(16'h1004));

        // Fill every lane with non-crossing flits, then reset mid-cycle.
        @(negedge clk);
        apply_stimulus_idle();
        apply_stimulus_heads();
        port_l0_i = flit(16'h1000); port_l1_i = flit(16'h1001);
        port_g0_i = flit(16'h1004); port_g1_i = flit(16'h1005);
        port_g2_i = flit(16'h1006); port_g3_i = flit(16'h1007);
        #1;
        check_output("full_deq", {138'd0, deq_vec}, '0);
        @(posedge clk); #1;
        check_output("full_out_l0", port_l0_o, flit(16'h1000));
        check_output("full_out_g3", port_g3_o, flit(16'h1007));
        #2;
        rst = 1'b1;
        port_l0_i = flit(16'h1004);
        #1;
        check_output("arst_out", out_or, '0);
        check_output("arst_deq", {138'd0, deq_vec}, '0);
        check_output("arst_enq", {138'd0, enq_vec}, '0);

        // Release and resume with empty lanes, then a fresh injection.
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus_idle();
        @(posedge clk); #1;
        check_output("resume_out", out_or, '0);
        @(negedge clk);
        FIFO_g2_i = flit(16'h1ee2);
        @(posedge clk); #1;
        check_output("resume_inj_g2", port_g2_o, flit(16'h1ee2));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
